calc_ctrl: RTL

Sequencing controller for the simple calculator. Consumes debounced key strobes, builds operands A and B as decimal-entered binary values, runs the selected operation (add, subtract, multiply, sequential divide), and drives `op_a`, `op_b`, `op_result` and `current_state` to the seven-segment display module. It owns the calculator state machine; the display only reads its state code.

---
 rtl/calc_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_ctrl.sv
// Calculator sequencing controller: decimal operand entry, operation dispatch and result chaining.
// Define CALC_DIV_EN to build the 16-iteration restoring divider and enable the '/' key.
`timescale 1ns/1ps
module calc_ctrl #(
  parameter int unsigned OP_MAX = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [31:0] op_result,
  output logic [2:0]  current_state,
  output logic        neg,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    StFirst    = 3'd0,
    StCalcul   = 3'd1,
    StSecond   = 3'd2,
    StEnter    = 3'd3,
    StResult   = 3'd4,
    StContinue = 3'd5
  } state_e;

  typedef enum logic [1:0] {OpAdd, OpSub, OpMul, OpDiv} op_e;

`ifdef CALC_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [31:0] res_q, res_d;
  logic        neg_q, neg_d, err_q, err_d, busy_q, busy_d;

  logic        is_digit, is_op, is_eq, is_clr;
  logic [3:0]  op_tmp;
  op_e         op_sel;
  logic [31:0] a_ext, b_ext;
  logic        a_fits, b_fits;
  logic        clr_all, res_digit;

  always_comb begin
    is_digit = key_valid && (key_code <= 4'd9);
    is_op    = key_valid && ((key_code inside {4'd10, 4'd11, 4'd12}) ||
                             (DivEn && key_code == 4'd13));
    is_eq    = key_valid && (key_code == 4'd14);
    is_clr   = key_valid && (key_code == 4'd15);
    op_tmp   = key_code - 4'd10;
    op_sel   = op_e'(op_tmp[1:0]);
    a_ext    = 32'(a_q) * 32'd10 + 32'(key_code);
    b_ext    = 32'(b_q) * 32'd10 + 32'(key_code);
    a_fits   = a_ext <= OP_MAX;
    b_fits   = b_ext <= OP_MAX;
  end

`ifdef CALC_DIV_EN
  logic [15:0] dv_rem_q, dv_rem_d, dv_quo_q, dv_quo_d;
  logic [3:0]  dv_cnt_q, dv_cnt_d;
  logic        dv_run_q, dv_run_d;
  logic [15:0] src_rem, src_quo, step_rem, step_quo;
  logic [16:0] dv_shift, dv_diff;
  logic        dv_ge;

  // One restoring step; the first step seeds from A so the load and iteration 1 share an edge.
  always_comb begin
    src_rem  = dv_run_q ? dv_rem_q : 16'd0;
    src_quo  = dv_run_q ? dv_quo_q : a_q;
    dv_shift = {src_rem, src_quo[15]};
    dv_diff  = dv_shift - {1'b0, b_q};
    // Partial remainder < 2*B, so bit 16 of the difference is exactly the borrow.
    dv_ge    = ~dv_diff[16];
    step_rem = dv_ge ? dv_diff[15:0] : dv_shift[15:0];
    step_quo = {src_quo[14:0], dv_ge};
  end
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    neg_d     = neg_q;
    err_d     = err_q;
    clr_all   = 1'b0;
    res_digit = 1'b0;
`ifdef CALC_DIV_EN
    dv_run_d  = 1'b0;
    dv_rem_d  = dv_rem_q;
    dv_quo_d  = dv_quo_q;
    dv_cnt_d  = dv_cnt_q;
`endif

    if (is_clr && state_q != StEnter) begin
      clr_all = 1'b1;
    end else begin
      case (state_q)
        StFirst: begin
          if (is_digit) begin
            if (a_fits) a_d = a_ext[15:0];
          end else if (is_op) begin
            op_d    = op_sel;
            state_d = StCalcul;
          end
        end
        StCalcul, StContinue: begin
          if (is_op) begin
            op_d = op_sel;
          end else if (is_digit) begin
            b_d     = {12'd0, key_code};
            state_d = StSecond;
          end
        end
        StSecond: begin
          if (is_digit) begin
            if (b_fits) b_d = b_ext[15:0];
          end else if (is_eq) begin
            state_d = StEnter;
          end
        end
        StEnter: begin
          neg_d = 1'b0;
          unique case (op_q)
            OpAdd: begin
              res_d   = 32'(a_q) + 32'(b_q);
              state_d = StResult;
            end
            OpSub: begin
              neg_d   = a_q < b_q;
              res_d   = (a_q < b_q) ? 32'(b_q - a_q) : 32'(a_q - b_q);
              state_d = StResult;
            end
            OpMul: begin
              res_d   = 32'(a_q) * 32'(b_q);
              state_d = StResult;
            end
            OpDiv: begin
`ifdef CALC_DIV_EN
              if (b_q == 16'd0) begin
                res_d   = 32'd0;
                err_d   = 1'b1;
                state_d = StResult;
              end else if (dv_run_q && dv_cnt_q == 4'd15) begin
                res_d   = {16'd0, step_quo};
                state_d = StResult;
              end else begin
                dv_run_d = 1'b1;
                dv_rem_d = step_rem;
                dv_quo_d = step_quo;
                dv_cnt_d = dv_run_q ? dv_cnt_q + 4'd1 : 4'd1;
              end
`else
              res_d   = 32'd0;
              state_d = StResult;
`endif
            end
          endcase
        end
        StResult: begin
          if (is_op) begin
            if (res_q <= OP_MAX && !neg_q) begin
              a_d     = res_q[15:0];
              b_d     = 16'd0;
              op_d    = op_sel;
              neg_d   = 1'b0;
              state_d = StContinue;
            end else begin
              err_d = 1'b1;
            end
          end else if (is_digit) begin
            clr_all   = 1'b1;
            res_digit = 1'b1;
          end
        end
        default: clr_all = 1'b1;
      endcase
    end

    if (clr_all) begin
      state_d = StFirst;
      op_d    = OpAdd;
      a_d     = 16'd0;
      b_d     = 16'd0;
      res_d   = 32'd0;
      neg_d   = 1'b0;
      err_d   = 1'b0;
    end
    if (res_digit) a_d = {12'd0, key_code};
    busy_d = (state_d == StEnter);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFirst;
      op_q     <= OpAdd;
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      res_q    <= 32'd0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef CALC_DIV_EN
      dv_run_q <= 1'b0;
      dv_rem_q <= 16'd0;
      dv_quo_q <= 16'd0;
      dv_cnt_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
`ifdef CALC_DIV_EN
      dv_run_q <= dv_run_d;
      dv_rem_q <= dv_rem_d;
      dv_quo_q <= dv_quo_d;
      dv_cnt_q <= dv_cnt_d;
`endif
    end
  end

  assign op_a          = a_q;
  assign op_b          = b_q;
  assign op_result     = res_q;
  assign current_state = state_q;
  assign neg           = neg_q;
  assign err           = err_q;
  assign busy          = busy_q;

endmodule
